// File: rtl/wb_arb2_pkg.sv
// rtl/wb_arb2_pkg.sv - shared types and constants for the two-master Wishbone arbiter
//   arb_state_t  : arbiter ownership state
//   ARB_GNT_*    : one-hot grant encodings driven on grant_o
//   cnt_width()  : width of the outstanding-request counter for a given MAXOUT
package wb_arb2_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] ARB_GNT_NONE = 2'b00;
    localparam logic [1:0] ARB_GNT_M0   = 2'b01;
    localparam logic [1:0] ARB_GNT_M1   = 2'b10;

    function automatic int cnt_width(input int maxout);
        return $clog2(maxout + 1);
    endfunction

endpackage

// File: rtl/wb_arb2_if.sv
// rtl/wb_arb2_if.sv - pipelined Wishbone bus bundle
//   cyc, stb, we, sel, adr, dat_w : master -> slave request
//   dat_r, ack, stall             : slave -> master response
//   modport master : the side that issues requests
//   modport slave  : the side that answers them
interface wb_arb2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            stall;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, stall
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, stall
    );
endinterface

// File: rtl/wb_outcnt.sv
// rtl/wb_outcnt.sv - saturating up/down counter of accepted-but-unacked requests
//   clk, rst : clock, asynchronous active-high reset
//   inc      : a request was accepted this cycle
//   dec      : an ack was returned this cycle
//   clr      : owner released the bus; forget anything still in flight
//   cnt      : current outstanding count
//   full     : cnt == MAXOUT
//   empty    : cnt == 0
module wb_outcnt
    import wb_arb2_pkg::*;
#(
    parameter int MAXOUT = 4,
    parameter int CW     = cnt_width(MAXOUT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty
);

    assign full  = (cnt == CW'(MAXOUT));
    assign empty = (cnt == '0);

    // Simultaneous inc and dec cancel; the saturation guards make the
    // counter safe even if a caller forgets to gate inc/dec.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - two-master / one-slave pipelined Wishbone arbiter
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   m0      : instruction-fetch master port (wb_arb2_if.slave)
//   m1      : data master port (wb_arb2_if.slave)
//   s       : shared downstream bus (wb_arb2_if.master)
//   grant_o : one-hot owner, 2'b00 when idle
// Build option WB_ARB2_RR_EN: ties in idle go to the master that did not own
// the bus last; otherwise m1 always wins ties.
module wb_arb2
    import wb_arb2_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int MAXOUT = 4    // legal range 1..15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_arb2_if.slave    m0,
    wb_arb2_if.slave    m1,
    wb_arb2_if.master   s,
    output logic [1:0]  grant_o
);

    localparam int CW = cnt_width(MAXOUT);

    arb_state_t    state;
    arb_state_t    next_state;
    logic [CW-1:0] cnt;
    logic          cnt_full;
    logic          cnt_empty;
    logic          cnt_inc;
    logic          cnt_dec;
    logic          cnt_clr;

    wb_outcnt #(
        .MAXOUT (MAXOUT),
        .CW     (CW)
    ) u_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (cnt_inc),
        .dec   (cnt_dec),
        .clr   (cnt_clr),
        .cnt   (cnt),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

`ifdef WB_ARB2_RR_EN
    logic last_owner;   // 0: m0 owned last, 1: m1 owned last

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_owner <= 1'b0;
        end else if (next_state != state && next_state != ARB_IDLE) begin
            last_owner <= (next_state == ARB_OWN1);
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_o    = ARB_GNT_NONE;
        s.cyc      = 1'b0;
        s.stb      = 1'b0;
        s.we       = 1'b0;
        s.sel      = {(DW/8){1'b0}};
        s.adr      = {AW{1'b0}};
        s.dat_w    = {DW{1'b0}};
        m0.stall   = 1'b1;
        m1.stall   = 1'b1;
        m0.ack     = 1'b0;
        m1.ack     = 1'b0;
        // Read data is broadcast; only the ack qualifies it.
        m0.dat_r   = s.dat_r;
        m1.dat_r   = s.dat_r;
        cnt_clr    = 1'b0;

        case (state)
            ARB_IDLE: begin
`ifdef WB_ARB2_RR_EN
                if (m0.cyc && m1.cyc) begin
                    next_state = last_owner ? ARB_OWN0 : ARB_OWN1;
                end else if (m1.cyc) begin
                    next_state = ARB_OWN1;
                end else if (m0.cyc) begin
                    next_state = ARB_OWN0;
                end
`else
                if (m1.cyc) begin
                    next_state = ARB_OWN1;
                end else if (m0.cyc) begin
                    next_state = ARB_OWN0;
                end
`endif
            end

            ARB_OWN0: begin
                grant_o  = ARB_GNT_M0;
                s.cyc    = m0.cyc;
                s.stb    = m0.stb & m0.cyc & ~cnt_full;
                s.we     = m0.we;
                s.sel    = m0.sel;
                s.adr    = m0.adr;
                s.dat_w  = m0.dat_w;
                m0.stall = s.stall | cnt_full;
                m0.ack   = s.ack & ~cnt_empty;
                if (!m0.cyc) begin
                    // Release: anything still in flight is abandoned.
                    cnt_clr    = 1'b1;
                    next_state = m1.cyc ? ARB_OWN1 : ARB_IDLE;
                end
            end

            ARB_OWN1: begin
                grant_o  = ARB_GNT_M1;
                s.cyc    = m1.cyc;
                s.stb    = m1.stb & m1.cyc & ~cnt_full;
                s.we     = m1.we;
                s.sel    = m1.sel;
                s.adr    = m1.adr;
                s.dat_w  = m1.dat_w;
                m1.stall = s.stall | cnt_full;
                m1.ack   = s.ack & ~cnt_empty;
                if (!m1.cyc) begin
                    cnt_clr    = 1'b1;
                    next_state = m0.cyc ? ARB_OWN0 : ARB_IDLE;
                end
            end

            default: begin
                next_state = ARB_IDLE;
            end
        endcase

        cnt_inc = s.stb & ~s.stall;
        // Acks with nothing outstanding are strays or belong to a released
        // owner; they must not disturb the count.
        cnt_dec = s.ack & ~cnt_empty;
    end

endmodule

// File: tb/tb_wb_arb2.sv
// tb/tb_wb_arb2.sv - directed self-checking bench for wb_arb2
module tb_wb_arb2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    int         tests = 0;
    int         fails = 0;
    int         acc;

    always #5 clk = ~clk;

    wb_arb2_if #(.AW(32), .DW(32)) m0_bus ();
    wb_arb2_if #(.AW(32), .DW(32)) m1_bus ();
    wb_arb2_if #(.AW(32), .DW(32)) s_bus ();

    wb_arb2 #(
        .AW     (32),
        .DW     (32),
        .MAXOUT (4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus),
        .grant_o (grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.sel = 4'h0;
        m0_bus.adr = 32'h0; m0_bus.dat_w = 32'h0;
        m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.sel = 4'h0;
        m1_bus.adr = 32'h0; m1_bus.dat_w = 32'h0;
        s_bus.dat_r = 32'h0; s_bus.ack = 0; s_bus.stall = 0;
        #3;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_s_cyc", 64'(s_bus.cyc), 64'h0);
        chk("rst_s_stb", 64'(s_bus.stb), 64'h0);
        chk("rst_s_we", 64'(s_bus.we), 64'h0);
        chk("rst_s_adr", 64'(s_bus.adr), 64'h0);
        chk("rst_m0_stall", 64'(m0_bus.stall), 64'h1);
        chk("rst_m1_stall", 64'(m1_bus.stall), 64'h1);
        chk("rst_m0_ack", 64'(m0_bus.ack), 64'h0);
        chk("rst_cnt", 64'(dut.u_cnt.cnt), 64'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // m0 single read
        m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.adr = 32'h0000_0100; m0_bus.sel = 4'hf;
        #1;
        chk("t1_idle_grant", 64'(grant), 64'h0);
        chk("t1_idle_stall", 64'(m0_bus.stall), 64'h1);
        tick();
        chk("t1_grant", 64'(grant), 64'h1);
        chk("t1_s_stb", 64'(s_bus.stb), 64'h1);
        chk("t1_s_adr", 64'(s_bus.adr), 64'h100);
        chk("t1_s_sel", 64'(s_bus.sel), 64'hf);
        chk("t1_m0_stall", 64'(m0_bus.stall), 64'h0);
        chk("t1_m1_stall", 64'(m1_bus.stall), 64'h1);
        tick();
        m0_bus.stb = 0;
        #1;
        chk("t1_no_early_ack", 64'(m0_bus.ack), 64'h0);
        tick();
        s_bus.ack = 1; s_bus.dat_r = 32'hDEAD_BEEF;
        #1;
        chk("t1_m0_ack", 64'(m0_bus.ack), 64'h1);
        chk("t1_m0_dat", 64'(m0_bus.dat_r), 64'hDEAD_BEEF);
        chk("t1_m1_ack", 64'(m1_bus.ack), 64'h0);
        tick();
        s_bus.ack = 0; m0_bus.cyc = 0;
        #1;
        chk("t1_rel_s_cyc", 64'(s_bus.cyc), 64'h0);
        chk("t1_rel_cnt", 64'(dut.u_cnt.cnt), 64'h0);
        tick();
        chk("t1_idle_again", 64'(grant), 64'h0);

        // simultaneous requests from idle
        m0_bus.cyc = 1; m1_bus.cyc = 1;
        tick();
        chk("t2_tie1", 64'(grant), 64'h2);
        m0_bus.cyc = 0; m1_bus.cyc = 0;
        tick();
        chk("t2_idle", 64'(grant), 64'h0);
        m0_bus.cyc = 1; m1_bus.cyc = 1;
        tick();
`ifdef WB_ARB2_RR_EN
        chk("t2_tie2_rr", 64'(grant), 64'h1);
`else
        chk("t2_tie2_fixed", 64'(grant), 64'h2);
`endif
        m0_bus.cyc = 0; m1_bus.cyc = 0;
        tick();

        // m1 streams 6 strobes, acks withheld
        m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.we = 1; m1_bus.adr = 32'h0000_2000;
        m1_bus.dat_w = 32'h1234_5678; m1_bus.sel = 4'h3;
        tick();
        #1;
        chk("t3_s_we", 64'(s_bus.we), 64'h1);
        chk("t3_s_dat", 64'(s_bus.dat_w), 64'h1234_5678);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (s_bus.stb && !s_bus.stall) acc++;
            tick();
            #1;
        end
        chk("t3_accepted", 64'(acc), 64'h4);
        chk("t3_full_stall", 64'(m1_bus.stall), 64'h1);
        chk("t3_full_stb", 64'(s_bus.stb), 64'h0);
        chk("t3_cnt4", 64'(dut.u_cnt.cnt), 64'h4);
        s_bus.ack = 1;
        #1;
        chk("t3_ack", 64'(m1_bus.ack), 64'h1);
        chk("t3_ack_stb", 64'(s_bus.stb), 64'h0);
        tick();
        s_bus.ack = 0;
        #1;
        chk("t3_fifth_stb", 64'(s_bus.stb), 64'h1);
        chk("t3_fifth_stall", 64'(m1_bus.stall), 64'h0);
        tick();
        m1_bus.stb = 0;
        for (int i = 0; i < 4; i++) begin
            s_bus.ack = 1;
            #1;
            chk("t3_drain_ack", 64'(m1_bus.ack), 64'h1);
            tick();
        end
        s_bus.ack = 0;
        #1;
        chk("t3_drained", 64'(dut.u_cnt.cnt), 64'h0);
        m1_bus.cyc = 0; m1_bus.we = 0;
        tick();

        // handoff m0 -> m1 without idle
        m0_bus.cyc = 1;
        tick();
        m1_bus.cyc = 1;
        tick();
        chk("t4_no_preempt", 64'(grant), 64'h1);
        chk("t4_m1_stalled", 64'(m1_bus.stall), 64'h1);
        m0_bus.cyc = 0;
        #1;
        chk("t4_gap_cyc", 64'(s_bus.cyc), 64'h0);
        chk("t4_gap_grant", 64'(grant), 64'h1);
        tick();
        chk("t4_handoff", 64'(grant), 64'h2);
        chk("t4_s_cyc", 64'(s_bus.cyc), 64'h1);

        // premature release with two outstanding
        m1_bus.stb = 1;
        tick(); tick();
        m1_bus.stb = 0;
        #1;
        chk("t5_cnt2", 64'(dut.u_cnt.cnt), 64'h2);
        m1_bus.cyc = 0; m0_bus.cyc = 1;
        #1;
        chk("t5_rel_cyc", 64'(s_bus.cyc), 64'h0);
        tick();
        chk("t5_grant", 64'(grant), 64'h1);
        chk("t5_cnt_clr", 64'(dut.u_cnt.cnt), 64'h0);
        s_bus.ack = 1;
        #1;
        chk("t5_late_m0", 64'(m0_bus.ack), 64'h0);
        chk("t5_late_m1", 64'(m1_bus.ack), 64'h0);
        tick();
        chk("t5_late2_m0", 64'(m0_bus.ack), 64'h0);
        tick();
        s_bus.ack = 0;
        #1;
        chk("t5_cnt_end", 64'(dut.u_cnt.cnt), 64'h0);
        m0_bus.cyc = 0;
        tick();

        // reset mid-burst
        m1_bus.cyc = 1; m1_bus.stb = 1;
        tick(); tick(); tick(); tick();
        m1_bus.stb = 0;
        #1;
        chk("t6_cnt3", 64'(dut.u_cnt.cnt), 64'h3);
        chk("t6_cyc_pre", 64'(s_bus.cyc), 64'h1);
        rst = 1'b1;
        #1;
        chk("t6_async_cyc", 64'(s_bus.cyc), 64'h0);
        chk("t6_async_grant", 64'(grant), 64'h0);
        chk("t6_async_cnt", 64'(dut.u_cnt.cnt), 64'h0);
        m1_bus.cyc = 0;
        tick();
        rst = 1'b0;
        tick();
        s_bus.ack = 1;
        #1;
        chk("t6_post_m0", 64'(m0_bus.ack), 64'h0);
        chk("t6_post_m1", 64'(m1_bus.ack), 64'h0);
        tick();
        chk("t6_post2_m1", 64'(m1_bus.ack), 64'h0);
        s_bus.ack = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
